// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: shadow scoreboard of EX/MEM/WB destinations
// driving PC/IF-ID hold, IF-ID flush and ID-EX bubble for the 5-stage core.
module hazard_ctrl #(
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             control_j,
    input  logic             mem_wait,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STALL  = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_FREEZE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             ex_v_q, ex_v_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic             mem_v_q, mem_v_d;
    logic [4:0]       mem_rd_q, mem_rd_d;
    logic             wb_v_q, wb_v_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       rs1_chk, rs2_chk;
    logic       hit_ex, hit_mem, hit_wb;
    logic       hz;
    logic [1:0] state_c;

    // x0 is never a real dependency, so it is excluded on the read side too
    always_comb begin
        rs1_chk = id_use_rs1 && (id_rs1 != 5'd0);
        rs2_chk = id_use_rs2 && (id_rs2 != 5'd0);
        hit_ex  = ex_v_q  && ((rs1_chk && (id_rs1 == ex_rd_q))  || (rs2_chk && (id_rs2 == ex_rd_q)));
        hit_mem = mem_v_q && ((rs1_chk && (id_rs1 == mem_rd_q)) || (rs2_chk && (id_rs2 == mem_rd_q)));
        hit_wb  = (WB_BYPASS == 0) && wb_v_q &&
                  ((rs1_chk && (id_rs1 == wb_rd_q)) || (rs2_chk && (id_rs2 == wb_rd_q)));
        hz      = id_valid && (hit_ex || hit_mem || hit_wb);
    end

    always_comb begin
        state_c = ST_RUN;
        if (mem_wait) begin
            state_c = ST_FREEZE;
        end else if (hz) begin
            state_c = ST_STALL;
        end else if (control_j && id_valid) begin
            state_c = ST_FLUSH;
        end
    end

    always_comb begin
        pc_hold     = (state_c == ST_FREEZE) || (state_c == ST_STALL);
        ifid_hold   = (state_c == ST_FREEZE) || (state_c == ST_STALL);
        idex_bubble = (state_c == ST_STALL);
        ifid_flush  = (state_c == ST_FLUSH);
        state       = state_c;
        stall_cnt   = stall_cnt_q;
        flush_cnt   = flush_cnt_q;
    end

    // Freeze holds everything; a stall injects an empty EX slot; run/flush issue ID
    always_comb begin
        ex_v_d      = ex_v_q;
        ex_rd_d     = ex_rd_q;
        mem_v_d     = mem_v_q;
        mem_rd_d    = mem_rd_q;
        wb_v_d      = wb_v_q;
        wb_rd_d     = wb_rd_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_c != ST_FREEZE) begin
            wb_v_d   = mem_v_q;
            wb_rd_d  = mem_rd_q;
            mem_v_d  = ex_v_q;
            mem_rd_d = ex_rd_q;
            if (state_c == ST_STALL) begin
                ex_v_d  = 1'b0;
                ex_rd_d = 5'd0;
            end else begin
                ex_v_d  = id_valid && id_reg_write && (id_rd != 5'd0);
                ex_rd_d = id_rd;
            end
        end
        if ((state_c == ST_STALL) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if ((state_c == ST_FLUSH) && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_v_q      <= 1'b0;
            ex_rd_q     <= 5'd0;
            mem_v_q     <= 1'b0;
            mem_rd_q    <= 5'd0;
            wb_v_q      <= 1'b0;
            wb_rd_q     <= 5'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_v_q      <= ex_v_d;
            ex_rd_q     <= ex_rd_d;
            mem_v_q     <= mem_v_d;
            mem_rd_q    <= mem_rd_d;
            wb_v_q      <= wb_v_d;
            wb_rd_q     <= wb_rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: u0 has WB bypass and wide counters,
// u1 compares the WB slot and uses 2-bit counters so saturation is reachable.
module tb_hazard_ctrl;

    localparam logic [5:0] C_RUN    = 6'b00_0000;
    localparam logic [5:0] C_STALL  = 6'b01_1101;
    localparam logic [5:0] C_FLUSH  = 6'b10_0010;
    localparam logic [5:0] C_FREEZE = 6'b11_1100;

    logic       clk;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_reg_write;
    logic       control_j, mem_wait;

    logic        ph0, ih0, fl0, bb0;
    logic [1:0]  st0;
    logic [31:0] sc0, fc0;
    logic        ph1, ih1, fl1, bb1;
    logic [1:0]  st1;
    logic [1:0]  sc1, fc1;
    logic [5:0]  ctl0, ctl1;

    int total;
    int passed;

    assign ctl0 = {st0, ph0, ih0, fl0, bb0};
    assign ctl1 = {st1, ph1, ih1, fl1, bb1};

    hazard_ctrl #(.WB_BYPASS(1), .CNT_W(32)) u0 (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .control_j(control_j), .mem_wait(mem_wait),
        .pc_hold(ph0), .ifid_hold(ih0), .ifid_flush(fl0), .idex_bubble(bb0),
        .state(st0), .stall_cnt(sc0), .flush_cnt(fc0)
    );

    hazard_ctrl #(.WB_BYPASS(0), .CNT_W(2)) u1 (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .control_j(control_j), .mem_wait(mem_wait),
        .pc_hold(ph1), .ifid_hold(ih1), .ifid_flush(fl1), .idex_bubble(bb1),
        .state(st1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Apply one ID-stage vector just after the edge; return at the falling edge for checks
    task automatic cyc(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic cj, input logic mw);
        @(posedge clk);
        #1;
        id_valid     = v;
        id_rs1       = rs1;
        id_use_rs1   = u1;
        id_rs2       = rs2;
        id_use_rs2   = u2;
        id_rd        = rd;
        id_reg_write = rw;
        control_j    = cj;
        mem_wait     = mw;
        @(negedge clk);
    endtask

    task automatic bubble();
        cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total        = 0;
        passed       = 0;
        reset_n      = 1'b0;
        id_valid     = 1'b0;
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        id_use_rs1   = 1'b0;
        id_use_rs2   = 1'b0;
        id_rd        = 5'd0;
        id_reg_write = 1'b0;
        control_j    = 1'b0;
        mem_wait     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl0", ctl0, C_RUN);
        chk("reset_ctl1", ctl1, C_RUN);
        chk("reset_sc0", sc0, 32'd0);
        chk("reset_fc0", fc0, 32'd0);
        chk("reset_sc1", sc1, 32'd0);
        chk("reset_fc1", fc1, 32'd0);
        reset_n = 1'b1;

        // addi x5 then add x6,x5,x1
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("raw_issue_ctl0", ctl0, C_RUN);
        cyc(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("raw_s1_ctl0", ctl0, C_STALL);
        chk("raw_s1_ctl1", ctl1, C_STALL);
        cyc(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("raw_s2_ctl0", ctl0, C_STALL);
        chk("raw_s2_ctl1", ctl1, C_STALL);
        cyc(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("raw_s3_ctl0", ctl0, C_RUN);
        chk("raw_s3_ctl1", ctl1, C_STALL);
        cyc(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("raw_s4_ctl0", ctl0, C_RUN);
        chk("raw_s4_ctl1", ctl1, C_RUN);
        chk("raw_sc0", sc0, 32'd2);
        chk("raw_sc1", sc1, 32'd3);
        repeat (3) bubble();

        // no-stall cases: non-writing producer, unused rs1, rs2 = x0
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
        chk("nows_ctl0", ctl0, C_RUN);
        cyc(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("nows_use_ctl0", ctl0, C_RUN);
        chk("nows_use_ctl1", ctl1, C_RUN);
        cyc(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("nouse_ctl0", ctl0, C_RUN);
        chk("nouse_ctl1", ctl1, C_RUN);
        cyc(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("rd0_ctl0", ctl0, C_RUN);
        chk("rd0_ctl1", ctl1, C_RUN);
        repeat (3) bubble();
        chk("nostall_sc0", sc0, 32'd2);

        // beq redirect with rd field 3 and no write
        cyc(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
        chk("flush_ctl0", ctl0, C_FLUSH);
        chk("flush_ctl1", ctl1, C_FLUSH);
        cyc(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("after_flush_ctl0", ctl0, C_RUN);
        chk("after_flush_ctl1", ctl1, C_RUN);
        chk("flush_fc0", fc0, 32'd1);
        chk("flush_fc1", fc1, 32'd1);
        repeat (3) bubble();

        // jalr reading x8 right behind its producer
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
        chk("jhz_s1_ctl0", ctl0, C_STALL);
        cyc(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
        chk("jhz_s2_ctl0", ctl0, C_STALL);
        chk("jhz_s2_ctl1", ctl1, C_STALL);
        cyc(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
        chk("jhz_fl_ctl0", ctl0, C_FLUSH);
        chk("jhz_s3_ctl1", ctl1, C_STALL);
        bubble();
        chk("jhz_fc0", fc0, 32'd2);
        chk("jhz_sc0", sc0, 32'd4);
        chk("sat_sc1", sc1, 32'd3);
        chk("jhz_fc1", fc1, 32'd1);
        repeat (2) bubble();

        // memory freeze while a RAW hazard is pending
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("frz_1_ctl0", ctl0, C_FREEZE);
        cyc(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("frz_2_ctl1", ctl1, C_FREEZE);
        cyc(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("frz_3_ctl0", ctl0, C_FREEZE);
        chk("frz_sc0", sc0, 32'd4);
        cyc(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("frz_s1_ctl0", ctl0, C_STALL);
        cyc(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("frz_s2_ctl0", ctl0, C_STALL);
        cyc(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("frz_end_ctl0", ctl0, C_RUN);
        chk("frz_s3_ctl1", ctl1, C_STALL);
        chk("frz_after_sc0", sc0, 32'd6);
        repeat (3) bubble();

        // redirect arriving during a freeze is deferred
        cyc(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("frz_j_ctl0", ctl0, C_FREEZE);
        cyc(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("frz_j_fl_ctl0", ctl0, C_FLUSH);
        chk("frz_j_fl_ctl1", ctl1, C_FLUSH);
        bubble();
        chk("frz_j_fc0", fc0, 32'd3);
        chk("frz_j_fc1", fc1, 32'd2);
        repeat (2) bubble();

        // asynchronous reset in the middle of a stall
        cyc(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_pre_ctl0", ctl0, C_STALL);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_ctl0", ctl0, C_RUN);
        chk("rst_ctl1", ctl1, C_RUN);
        chk("rst_sc0", sc0, 32'd0);
        chk("rst_fc0", fc0, 32'd0);
        chk("rst_sc1", sc1, 32'd0);
        #1 reset_n = 1'b1;
        bubble();
        chk("rst_next_sc0", sc0, 32'd0);
        chk("rst_next_sc1", sc1, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
